// File: rtl/crc_stream_engine_if.sv
// Stream and result handshake bundle for crc_stream_engine.
//   check_mode, abort           : frame control, driven by the source
//   s_valid/s_ready/s_data/s_last : input beat handshake
//   crc_valid/crc_ready         : result handshake
//   crc_out, crc_match          : result payload
interface crc_stream_engine_if #(
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned CRC_LEN = 32
);
   logic                check_mode;
   logic                abort;
   logic                s_valid;
   logic                s_ready;
   logic [DATA_W-1:0]   s_data;
   logic                s_last;
   logic                crc_valid;
   logic                crc_ready;
   logic [CRC_LEN-1:0]  crc_out;
   logic                crc_match;

   // Engine side
   modport slave (
      input  check_mode, abort, s_valid, s_data, s_last, crc_ready,
      output s_ready, crc_valid, crc_out, crc_match
   );

   // Source / consumer side
   modport master (
      output check_mode, abort, s_valid, s_data, s_last, crc_ready,
      input  s_ready, crc_valid, crc_out, crc_match
   );
endinterface

// File: rtl/crc_stream_engine.sv
// Multi-bit-per-cycle CRC engine over a framed valid/ready stream.
// Generate mode returns the finished CRC; check mode also flags a good residue
// over data plus appended CRC.
//   clk_in : clock, rising edge
//   reset  : synchronous, active-high
//   bus    : crc_stream_engine_if.slave (beat input, frame control, result output)
module crc_stream_engine #(
   parameter int unsigned              CRC_LEN     = 32,
   parameter logic [CRC_LEN-1:0]       POLYNOMIAL  = CRC_LEN'(32'h04C11DB7),
   parameter int unsigned              DATA_W      = 8,
   parameter logic [CRC_LEN-1:0]       INIT        = '1,
   parameter logic [CRC_LEN-1:0]       XOR_OUT     = '1,
   parameter bit                       REFLECT_IN  = 1'b1,
   parameter bit                       REFLECT_OUT = 1'b1,
   parameter logic [CRC_LEN-1:0]       RESIDUE     = CRC_LEN'(32'hC704DD7B)
) (
   input  logic                 clk_in,
   input  logic                 reset,
   crc_stream_engine_if.slave   bus
);

   localparam int unsigned N_BYTES = DATA_W / 8;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]          r_state,     w_state_nx;
   logic [CRC_LEN-1:0]  r_crc,       w_crc_nx;
   logic [CRC_LEN-1:0]  r_crc_out,   w_crc_out_nx;
   logic                r_mode,      w_mode_nx;
   logic                r_s_ready,   w_s_ready_nx;
   logic                r_crc_valid, w_crc_valid_nx;
   logic                r_crc_match, w_crc_match_nx;
   logic [CRC_LEN-1:0]  w_crc_step;
   logic [CRC_LEN-1:0]  w_crc_final;
   logic                w_accept;
   logic                w_mode_eff;

   function automatic logic [CRC_LEN-1:0] f_bitrev(input logic [CRC_LEN-1:0] x);
      logic [CRC_LEN-1:0] r;
      r = '0;
      for (int unsigned i = 0; i < CRC_LEN; i++) r[i] = x[CRC_LEN-1-i];
      return r;
   endfunction

   // Unrolled serial Galois shift over every bit of the beat, byte 0 first
   always_comb begin
      logic [CRC_LEN-1:0] v_reg;
      logic [7:0]         v_byte;
      logic               v_fb;
      v_reg  = (r_state == ST_IDLE) ? INIT : r_crc;
      v_byte = '0;
      v_fb   = 1'b0;
      for (int unsigned b = 0; b < N_BYTES; b++) begin
         if (REFLECT_IN) v_byte = bus.s_data[8*b +: 8];
         else            v_byte = bus.s_data[DATA_W-8-8*b +: 8];
         for (int unsigned k = 0; k < 8; k++) begin
            v_fb  = v_reg[CRC_LEN-1] ^ (REFLECT_IN ? v_byte[k] : v_byte[7-k]);
            v_reg = {v_reg[CRC_LEN-2:0], 1'b0} ^ ({CRC_LEN{v_fb}} & POLYNOMIAL);
         end
      end
      w_crc_step = v_reg;
   end

   assign w_crc_final = (REFLECT_OUT ? f_bitrev(w_crc_step) : w_crc_step) ^ XOR_OUT;
   assign w_accept    = bus.s_valid & r_s_ready;
   // Mode applies from the first beat of the frame onward
   assign w_mode_eff  = (r_state == ST_IDLE) ? bus.check_mode : r_mode;

   // Next-state and next-output logic
   always_comb begin
      w_state_nx     = r_state;
      w_crc_nx       = r_crc;
      w_mode_nx      = r_mode;
      w_crc_valid_nx = r_crc_valid;
      w_crc_out_nx   = r_crc_out;
      w_crc_match_nx = r_crc_match;

      case (r_state)
         ST_IDLE, ST_BUSY: begin
            if (w_accept) begin
               w_crc_nx  = w_crc_step;
               w_mode_nx = w_mode_eff;
               if (bus.s_last) begin
                  w_state_nx     = ST_DONE;
                  w_crc_valid_nx = 1'b1;
                  w_crc_out_nx   = w_crc_final;
                  w_crc_match_nx = w_mode_eff & (w_crc_step == RESIDUE);
               end else begin
                  w_state_nx = ST_BUSY;
               end
            end
         end
         ST_DONE: begin
            if (bus.crc_ready) begin
               w_state_nx     = ST_IDLE;
               w_crc_nx       = INIT;
               w_crc_valid_nx = 1'b0;
            end
         end
         default: begin
            w_state_nx     = ST_IDLE;
            w_crc_nx       = INIT;
            w_crc_valid_nx = 1'b0;
         end
      endcase

      // Abort overrides everything, including a beat accepted this cycle
      if (bus.abort) begin
         w_state_nx     = ST_IDLE;
         w_crc_nx       = INIT;
         w_crc_valid_nx = 1'b0;
      end

      w_s_ready_nx = (w_state_nx != ST_DONE);
   end

   // State and output registers
   always_ff @(posedge clk_in) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_crc       <= INIT;
         r_mode      <= 1'b0;
         r_s_ready   <= 1'b1;
         r_crc_valid <= 1'b0;
         r_crc_out   <= '0;
         r_crc_match <= 1'b0;
      end else begin
         r_state     <= w_state_nx;
         r_crc       <= w_crc_nx;
         r_mode      <= w_mode_nx;
         r_s_ready   <= w_s_ready_nx;
         r_crc_valid <= w_crc_valid_nx;
         r_crc_out   <= w_crc_out_nx;
         r_crc_match <= w_crc_match_nx;
      end
   end

   assign bus.s_ready   = r_s_ready;
   assign bus.crc_valid = r_crc_valid;
   assign bus.crc_out   = r_crc_out;
   assign bus.crc_match = r_crc_match;

endmodule

// File: tb/tb_crc_stream_engine.sv
// Self-checking bench for crc_stream_engine: CRC-32 at 8 and 32 bits per beat,
// and CRC-16/CCITT-FALSE at 8 bits per beat, against byte-wise reference models.
module tb_crc_stream_engine;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        v, l, cm, ab, crdy;
   logic [7:0]  d;
   logic        v32, l32, cm32, ab32, crdy32;
   logic [31:0] d32;

   int n_checks = 0;
   int n_err    = 0;

   crc_stream_engine_if #(.DATA_W(8),  .CRC_LEN(32)) if8  ();
   crc_stream_engine_if #(.DATA_W(8),  .CRC_LEN(16)) if16 ();
   crc_stream_engine_if #(.DATA_W(32), .CRC_LEN(32)) if32 ();

   assign if8.s_valid     = v;   assign if16.s_valid     = v;
   assign if8.s_data      = d;   assign if16.s_data      = d;
   assign if8.s_last      = l;   assign if16.s_last      = l;
   assign if8.check_mode  = cm;  assign if16.check_mode  = cm;
   assign if8.abort       = ab;  assign if16.abort       = ab;
   assign if8.crc_ready   = crdy; assign if16.crc_ready  = crdy;
   assign if32.s_valid    = v32;
   assign if32.s_data     = d32;
   assign if32.s_last     = l32;
   assign if32.check_mode = cm32;
   assign if32.abort      = ab32;
   assign if32.crc_ready  = crdy32;

   crc_stream_engine u_dut8 (.clk_in(clk), .reset(rst), .bus(if8.slave));

   crc_stream_engine #(
      .CRC_LEN(16), .POLYNOMIAL(16'h1021), .DATA_W(8), .INIT(16'hFFFF),
      .XOR_OUT(16'h0000), .REFLECT_IN(1'b0), .REFLECT_OUT(1'b0), .RESIDUE(16'h0000)
   ) u_dut16 (.clk_in(clk), .reset(rst), .bus(if16.slave));

   crc_stream_engine #(.DATA_W(32)) u_dut32 (.clk_in(clk), .reset(rst), .bus(if32.slave));

   // Reflected byte-wise CRC-32, state before the final XOR
   function automatic logic [31:0] m32_raw(input logic [7:0] q[$]);
      logic [31:0] c;
      c = 32'hFFFFFFFF;
      foreach (q[i]) begin
         c = c ^ {24'h0, q[i]};
         for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
      return c;
   endfunction

   function automatic logic [31:0] m32_out(input logic [7:0] q[$]);
      return m32_raw(q) ^ 32'hFFFFFFFF;
   endfunction

   // A good CRC-32 frame leaves the reflected state at the standard residue
   function automatic logic m32_match(input logic [7:0] q[$], input logic mode);
      return mode && (m32_raw(q) == 32'hDEBB20E3);
   endfunction

   // MSB-first byte-wise CRC-16/CCITT-FALSE
   function automatic logic [15:0] m16_out(input logic [7:0] q[$]);
      logic [15:0] c;
      c = 16'hFFFF;
      foreach (q[i]) begin
         c = c ^ {q[i], 8'h00};
         for (int k = 0; k < 8; k++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
      end
      return c;
   endfunction

   function automatic logic m16_match(input logic [7:0] q[$], input logic mode);
      return mode && (m16_out(q) == 16'h0000);
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present one beat to the 8-bit engines and wait (bounded) until it is taken
   task automatic beat8(input logic [7:0] b, input logic last);
      logic acc;
      int   n;
      v = 1'b1; d = b; l = last; n = 0;
      do begin
         acc = if8.s_ready;
         @(posedge clk); #1;
         n++;
      end while (!acc && n < 16);
      chk("beat8_accept", 64'(acc), 64'(1));
   endtask

   task automatic frame8(input logic [7:0] q[$], input logic mode);
      cm = mode;
      for (int i = 0; i < q.size(); i++) begin
         beat8(q[i], i == q.size() - 1);
         if (i != q.size() - 1) chk("busy_valid8", 64'(if8.crc_valid), 64'(0));
      end
   endtask

   task automatic result8(input logic [7:0] q[$], input logic mode);
      chk("valid8",  64'(if8.crc_valid),  64'(1));
      chk("valid16", 64'(if16.crc_valid), 64'(1));
      chk("sready8", 64'(if8.s_ready),    64'(0));
      chk("out8",    64'(if8.crc_out),    64'(m32_out(q)));
      chk("out16",   64'(if16.crc_out),   64'(m16_out(q)));
      chk("match8",  64'(if8.crc_match),  64'(m32_match(q, mode)));
      chk("match16", 64'(if16.crc_match), 64'(m16_match(q, mode)));
   endtask

   task automatic idle_after8();
      v = 1'b0;
      @(posedge clk); #1;
      chk("idle_valid8",  64'(if8.crc_valid), 64'(0));
      chk("idle_sready8", 64'(if8.s_ready),   64'(1));
   endtask

   task automatic frame32(input logic [7:0] q[$], input logic mode);
      logic acc;
      int   n;
      cm32 = mode;
      for (int i = 0; i < q.size() / 4; i++) begin
         v32 = 1'b1; l32 = (i == q.size() / 4 - 1);
         d32 = {q[4*i+3], q[4*i+2], q[4*i+1], q[4*i]};
         n = 0;
         do begin
            acc = if32.s_ready;
            @(posedge clk); #1;
            n++;
         end while (!acc && n < 16);
         chk("beat32_accept", 64'(acc), 64'(1));
      end
      chk("valid32", 64'(if32.crc_valid), 64'(1));
      chk("out32",   64'(if32.crc_out),   64'(m32_out(q)));
      chk("match32", 64'(if32.crc_match), 64'(m32_match(q, mode)));
      v32 = 1'b0;
   endtask

   task automatic reset_state(input string tag);
      chk({tag, "_sready8"},  64'(if8.s_ready),    64'(1));
      chk({tag, "_valid8"},   64'(if8.crc_valid),  64'(0));
      chk({tag, "_out8"},     64'(if8.crc_out),    64'(0));
      chk({tag, "_match8"},   64'(if8.crc_match),  64'(0));
      chk({tag, "_valid16"},  64'(if16.crc_valid), 64'(0));
      chk({tag, "_out16"},    64'(if16.crc_out),   64'(0));
      chk({tag, "_sready32"}, 64'(if32.s_ready),   64'(1));
      chk({tag, "_valid32"},  64'(if32.crc_valid), 64'(0));
      chk({tag, "_out32"},    64'(if32.crc_out),   64'(0));
   endtask

   initial begin
      logic [7:0]  q[$];
      logic [7:0]  f2[$];
      logic [7:0]  std[$];
      logic [31:0] c;
      logic        mode;
      int          len;

      rst = 1'b1;
      v = 1'b0; l = 1'b0; cm = 1'b0; ab = 1'b0; crdy = 1'b1; d = '0;
      v32 = 1'b0; l32 = 1'b0; cm32 = 1'b0; ab32 = 1'b0; crdy32 = 1'b1; d32 = '0;
      repeat (2) @(posedge clk);
      #1;
      reset_state("rst");
      rst = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 9; i++) std.push_back(8'(8'h31 + i));

      // "123456789" generate, latency one cycle after last beat
      frame8(std, 1'b0);
      result8(std, 1'b0);
      chk("std_crc32",  64'(if8.crc_out),  64'(32'hCBF43926));
      chk("std_crc16",  64'(if16.crc_out), 64'(16'h29B1));
      idle_after8();

      // Check mode: data + little-endian CRC gives a good residue
      q = std;
      q.push_back(8'h26); q.push_back(8'h39); q.push_back(8'hF4); q.push_back(8'hCB);
      frame8(q, 1'b1);
      result8(q, 1'b1);
      chk("chk_good", 64'(if8.crc_match), 64'(1));
      idle_after8();
      q[3] = q[3] ^ 8'h10;
      frame8(q, 1'b1);
      result8(q, 1'b1);
      chk("chk_bad", 64'(if8.crc_match), 64'(0));
      idle_after8();

      // Abort after 4 beats, with a simultaneous beat that must be dropped
      for (int i = 0; i < 4; i++) beat8(8'(8'hA0 + i), 1'b0);
      ab = 1'b1; v = 1'b1; d = 8'h55; l = 1'b0;
      @(posedge clk); #1;
      ab = 1'b0; v = 1'b0;
      chk("abort_valid8",  64'(if8.crc_valid), 64'(0));
      chk("abort_sready8", 64'(if8.s_ready),   64'(1));
      frame8(std, 1'b0);
      result8(std, 1'b0);
      chk("post_abort_crc", 64'(if8.crc_out), 64'(32'hCBF43926));
      idle_after8();

      // Abort while a result is pending
      crdy = 1'b0;
      frame8(std, 1'b0);
      result8(std, 1'b0);
      v = 1'b0; ab = 1'b1;
      @(posedge clk); #1;
      ab = 1'b0; crdy = 1'b1;
      chk("abort_done_valid8", 64'(if8.crc_valid), 64'(0));

      // Reset mid-frame
      for (int i = 0; i < 3; i++) beat8(8'(8'h10 + i), 1'b0);
      v = 1'b0; rst = 1'b1;
      @(posedge clk); #1;
      reset_state("midrst");
      rst = 1'b0;
      frame8(std, 1'b0);
      result8(std, 1'b0);
      idle_after8();

      // Back-to-back frames with s_valid held through the result cycle
      f2.delete();
      for (int i = 0; i < 5; i++) f2.push_back(8'($urandom));
      frame8(std, 1'b0);
      result8(std, 1'b0);
      frame8(f2, 1'b0);
      result8(f2, 1'b0);
      frame8(std, 1'b0);
      result8(std, 1'b0);
      idle_after8();

      // Randomized frames, 8-bit engines
      for (int t = 0; t < 20; t++) begin
         q.delete();
         len  = $urandom_range(1, 12);
         mode = 1'($urandom_range(0, 1));
         for (int i = 0; i < len; i++) q.push_back(8'($urandom));
         if (mode) begin
            c = m32_out(q);
            for (int b = 0; b < 4; b++) q.push_back(c[8*b +: 8]);
            if ($urandom_range(0, 1) == 1) begin
               len = $urandom_range(0, q.size() - 1);
               q[len] = q[len] ^ 8'(1 << $urandom_range(0, 7));
            end
         end
         frame8(q, mode);
         result8(q, mode);
         idle_after8();
      end

      // 32-bit beats: 16-byte frame with the result held for 5 cycles
      q.delete();
      for (int i = 0; i < 16; i++) q.push_back(8'($urandom));
      frame8(q, 1'b0);
      result8(q, 1'b0);
      idle_after8();
      crdy32 = 1'b0;
      frame32(q, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("hold_sready32", 64'(if32.s_ready),   64'(0));
         chk("hold_valid32",  64'(if32.crc_valid), 64'(1));
         chk("hold_out32",    64'(if32.crc_out),   64'(m32_out(q)));
      end
      crdy32 = 1'b1;
      @(posedge clk); #1;
      chk("rel_valid32", 64'(if32.crc_valid), 64'(0));

      // 32-bit check mode and random frames
      q = std;
      q.push_back(8'h30); q.push_back(8'h30); q.push_back(8'h30);
      c = m32_out(q);
      for (int b = 0; b < 4; b++) q.push_back(c[8*b +: 8]);
      frame32(q, 1'b1);
      chk("chk32_good", 64'(if32.crc_match), 64'(1));
      @(posedge clk); #1;
      for (int t = 0; t < 8; t++) begin
         q.delete();
         len  = 4 * $urandom_range(1, 4);
         mode = 1'($urandom_range(0, 1));
         for (int i = 0; i < len; i++) q.push_back(8'($urandom));
         if (mode) begin
            c = m32_out(q);
            for (int b = 0; b < 4; b++) q.push_back(c[8*b +: 8]);
            if ($urandom_range(0, 1) == 1) q[0] = q[0] ^ 8'h01;
         end
         frame32(q, mode);
         @(posedge clk); #1;
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
